// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word transmitter: FSM encoding, mode-0 constants,
// and a frame-length helper (cycles cs_n stays low) used by benches.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        HOLD     = 2'd3
    } spi_state_e;

    localparam int DATA_W_DFLT = 24;

    // Mode 0: sclk idles low, data launched on falling edge, sampled on rising edge.
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

    function automatic int frame_cycles(input int data_w, input int clk_div);
        return 2 * clk_div * data_w + clk_div;
    endfunction

endpackage

// File: rtl/spi_word_tx_if.sv
// Handshake and SPI pins of spi_word_tx; miso/rx_data exist only with SPI_READBACK_EN.
// slave is the transmitter side, master is the controller side.
interface spi_word_tx_if #(
    parameter int DATA_W = 24
);
    logic              load_data;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done_send;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
`ifdef SPI_READBACK_EN
    logic              miso;
    logic [DATA_W-1:0] rx_data;

    modport slave (
        input  load_data, data_in, miso,
        output busy, done_send, sclk, mosi, cs_n, rx_data
    );
    modport master (
        output load_data, data_in, miso,
        input  busy, done_send, sclk, mosi, cs_n, rx_data
    );
`else
    modport slave (
        input  load_data, data_in,
        output busy, done_send, sclk, mosi, cs_n
    );
    modport master (
        output load_data, data_in,
        input  busy, done_send, sclk, mosi, cs_n
    );
`endif
endinterface

// File: rtl/spi_clk_tick.sv
// Half-period divider: half_done pulses on every CLK_DIV-th enabled cycle, counter clears while
// disabled and restarts from 0 after each pulse. No backpressure.
module spi_clk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic half_done
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        half_done = en && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d     = cnt_q;
        if (!en || half_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_word_tx.sv
// SPI mode-0 word transmitter, MSB first; done_send 1+2*CLK_DIV*DATA_W+CLK_DIV cycles after load,
// loads outside IDLE are dropped. SPI_READBACK_EN adds miso capture into rx_data.
module spi_word_tx
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_word_tx_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_en;
    logic              half_done;
`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
`endif

    assign tick_en = (state_q != IDLE);

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (tick_en),
        .half_done (half_done)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.load_data) begin
                    shreg_d   = bus.data_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (half_done) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (half_done) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        state_d   = SHIFT_LO;
                    end
                end
            end
            HOLD: begin
                if (half_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are decoded from the next state and registered so they never glitch.
        sclk_d = (state_d == SHIFT_HI);
        cs_n_d = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        mosi_d = (state_d != IDLE) ? shreg_d[DATA_W-1] : 1'b0;
    end

`ifdef SPI_READBACK_EN
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        if (state_q == IDLE && bus.load_data) begin
            rx_shift_d = '0;
        end else if (state_q == SHIFT_LO && half_done) begin
            // This edge is the one where sclk rises.
            rx_shift_d = (rx_shift_q << 1) | DATA_W'(bus.miso);
        end
        if (done_d) rx_data_d = rx_shift_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_READBACK_EN
            rx_shift_q <= '0;
            rx_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SPI_READBACK_EN
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
`endif
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.mosi      = mosi_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.busy      = busy_q;
    assign bus.done_send = done_q;
`ifdef SPI_READBACK_EN
    assign bus.rx_data   = rx_data_q;
`endif

endmodule
